// File: rtl/game_pkg.sv
// Shared types and helpers for the score keeper: state/winner encodings, widths.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package game_pkg;

    localparam int SCORE_W = 4;
    localparam int TIME_W  = 7;

    // Match controller states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PLAYING    = 2'd1,
        GOAL_PAUSE = 2'd2,
        OVER       = 2'd3
    } state_t;

    // Winner codes as seen by the display logic
    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_BLUE = 2'b01,
        WIN_RED  = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Add one goal when inc is set, holding at the counter ceiling
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                   input logic               inc);
        if (inc && (s != SCORE_MAX)) begin
            return s + SCORE_W'(1);
        end
        return s;
    endfunction

    // Higher score wins; equal scores are a draw
    function automatic winner_t decide_winner(input logic [SCORE_W-1:0] blue,
                                              input logic [SCORE_W-1:0] red);
        if (blue > red) begin
            return WIN_BLUE;
        end
        if (red > blue) begin
            return WIN_RED;
        end
        return WIN_DRAW;
    endfunction

endpackage

// File: rtl/score_keeper_toggle_edge_detector.sv
// Turns level transitions into registered one-cycle pulses (any edge, or rising only).
// Latency: a transition sampled at edge N appears on pulse_o after edge N.
// Backpressure: none; every transition produces exactly one pulse.
module toggle_edge_detector #(
    parameter int WIDTH       = 1,
    parameter bit RISING_ONLY = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sig_i,
    output logic [WIDTH-1:0] pulse_o
);

    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] pulse_q;
    logic [WIDTH-1:0] pulse_d;

    // Compare the live input with last cycle's value
    always_comb begin
        pulse_d = '0;
        if (RISING_ONLY) begin
            pulse_d = sig_i & ~hist_q;
        end else begin
            pulse_d = sig_i ^ hist_q;
        end
    end

    // History tracks the input even in reset so a held level never looks like an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q  <= sig_i;
            pulse_q <= '0;
        end else begin
            hist_q  <= sig_i;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/score_keeper.sv
// Match controller: counts goal toggles, runs the match clock, sequences pauses, picks winner.
// Latency: goal toggle sampled at edge N updates score/state at edge N+1; all outputs registered.
// Backpressure: none; goals outside PLAYING/GOAL_PAUSE are dropped, start ignored mid-match.
module score_keeper
    import game_pkg::*;
#(
    parameter int CLK_FREQ      = 25000000,
    parameter int WIN_SCORE     = 5,
    parameter int MATCH_SECONDS = 90,
    parameter int PAUSE_CYCLES  = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_button,
    input  logic               blue_score_up,
    input  logic               red_score_up,
    output logic               game_initiated,
    output logic               game_over,
    output logic [SCORE_W-1:0] blue_score,
    output logic [SCORE_W-1:0] red_score,
    output logic [TIME_W-1:0]  time_left,
    output logic [1:0]         winner
);

    localparam int SEC_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int PAUSE_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(CLK_FREQ - 1);
    localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(PAUSE_CYCLES - 1);
    localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(MATCH_SECONDS);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    // Goal pulses: bit 0 blue, bit 1 red
    logic [1:0] goal_pulse;
    logic       start_pulse;

    toggle_edge_detector #(
        .WIDTH       (2),
        .RISING_ONLY (1'b0)
    ) u_goal_det (
        .clk     (clk),
        .reset   (reset),
        .sig_i   ({red_score_up, blue_score_up}),
        .pulse_o (goal_pulse)
    );

    toggle_edge_detector #(
        .WIDTH       (1),
        .RISING_ONLY (1'b1)
    ) u_start_det (
        .clk     (clk),
        .reset   (reset),
        .sig_i   (start_button),
        .pulse_o (start_pulse)
    );

    state_t             state_q;
    winner_t            winner_q;
    logic [SCORE_W-1:0] blue_q;
    logic [SCORE_W-1:0] red_q;
    logic [TIME_W-1:0]  time_q;
    logic [SEC_W-1:0]   sec_q;
    logic [PAUSE_W-1:0] pause_q;

    logic [SCORE_W-1:0] blue_d;
    logic [SCORE_W-1:0] red_d;
    logic [TIME_W-1:0]  time_d;
    logic [SEC_W-1:0]   sec_d;
    logic               sec_wrap;
    logic               expire;
    logic               win_hit;
    logic               any_goal;

    // Candidate in-match updates: scores with this cycle's goals, next match-clock values
    always_comb begin
        blue_d   = sat_inc(blue_q, goal_pulse[0]);
        red_d    = sat_inc(red_q, goal_pulse[1]);
        any_goal = |goal_pulse;
        win_hit  = (blue_d == WIN_VAL) || (red_d == WIN_VAL);
        sec_wrap = (sec_q == SEC_LAST);
        sec_d    = sec_wrap ? '0 : sec_q + SEC_W'(1);
        time_d   = time_q;
        expire   = 1'b0;
        if (sec_wrap) begin
            time_d = time_q - TIME_W'(1);
            expire = (time_q == TIME_W'(1));
        end
    end

    // Match state machine; goals are folded in before the end-of-match decision
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            winner_q <= WIN_NONE;
            blue_q   <= '0;
            red_q    <= '0;
            time_q   <= TIME_INIT;
            sec_q    <= '0;
            pause_q  <= '0;
        end else begin
            case (state_q)
                IDLE, OVER: begin
                    // Scores and clock stay frozen until a new start edge
                    if (start_pulse) begin
                        state_q  <= PLAYING;
                        winner_q <= WIN_NONE;
                        blue_q   <= '0;
                        red_q    <= '0;
                        time_q   <= TIME_INIT;
                        sec_q    <= '0;
                        pause_q  <= '0;
                    end
                end
                PLAYING, GOAL_PAUSE: begin
                    blue_q <= blue_d;
                    red_q  <= red_d;
                    sec_q  <= sec_d;
                    time_q <= time_d;
                    if (win_hit || expire) begin
                        state_q  <= OVER;
                        winner_q <= decide_winner(blue_d, red_d);
                    end else if (state_q == PLAYING) begin
                        if (any_goal) begin
                            state_q <= GOAL_PAUSE;
                            pause_q <= PAUSE_LOAD;
                        end
                    end else begin
                        // Late goals during the pause count but do not restart it
                        if (pause_q == '0) begin
                            state_q <= PLAYING;
                        end else begin
                            pause_q <= pause_q - PAUSE_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign game_initiated = (state_q == PLAYING);
    assign game_over      = (state_q == OVER);
    assign blue_score     = blue_q;
    assign red_score      = red_q;
    assign time_left      = time_q;
    assign winner         = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a short match: 10-cycle seconds, 3 goals to win,
// 5-second match, 4-cycle goal pause. Inputs change and outputs are sampled 1 time unit
// after each rising clock edge.
module tb_score_keeper;

    logic       clk;
    logic       reset;
    logic       start_button;
    logic       blue_score_up;
    logic       red_score_up;
    logic       game_initiated;
    logic       game_over;
    logic [3:0] blue_score;
    logic [3:0] red_score;
    logic [6:0] time_left;
    logic [1:0] winner;

    int n_cmp = 0;
    int n_err = 0;

    score_keeper #(
        .CLK_FREQ      (10),
        .WIN_SCORE     (3),
        .MATCH_SECONDS (5),
        .PAUSE_CYCLES  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_button   (start_button),
        .blue_score_up  (blue_score_up),
        .red_score_up   (red_score_up),
        .game_initiated (game_initiated),
        .game_over      (game_over),
        .blue_score     (blue_score),
        .red_score      (red_score),
        .time_left      (time_left),
        .winner         (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start edge: pulse registered at the first edge, PLAYING after the second
    task automatic start_match();
        start_button = 1'b1;
        tick();
        start_button = 1'b0;
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        start_button  = 1'b0;
        blue_score_up = 1'b1;
        red_score_up  = 1'b0;

        // Reset with blue toggle held high: no phantom goal afterwards
        repeat (3) tick();
        check("rst_gi", game_initiated, 0);
        reset = 1'b0;
        repeat (2) tick();
        check("idle_gi", game_initiated, 0);
        check("idle_go", game_over, 0);
        check("idle_blue", blue_score, 0);
        check("idle_red", red_score, 0);
        check("idle_time", time_left, 5);
        check("idle_winner", winner, 0);

        // Start, then a red goal and the 4-cycle pause
        start_match();
        check("start_gi", game_initiated, 1);
        check("start_time", time_left, 5);
        red_score_up = 1'b1;
        tick();
        check("red_lat_edgeN", red_score, 0);
        check("red_lat_gi", game_initiated, 1);
        tick();
        check("red_goal", red_score, 1);
        check("pause_gi0", game_initiated, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("pause_gi", game_initiated, 0);
        end
        tick();
        check("pause_end_gi", game_initiated, 1);

        // Three blue goals 20 cycles apart: win for blue before the clock runs out
        for (int k = 0; k < 3; k++) begin
            blue_score_up = ~blue_score_up;
            repeat (20) tick();
        end
        check("bwin_blue", blue_score, 3);
        check("bwin_red", red_score, 1);
        check("bwin_go", game_over, 1);
        check("bwin_gi", game_initiated, 0);
        check("bwin_winner", winner, 1);
        check("bwin_time_frozen", time_left, 1);
        blue_score_up = ~blue_score_up;
        repeat (3) tick();
        check("over_ignores_goal", blue_score, 3);

        // Goal-less match: one second every 10 cycles, draw at time-out
        start_match();
        check("t_blue_clr", blue_score, 0);
        check("t_red_clr", red_score, 0);
        check("t_winner_clr", winner, 0);
        check("t_gi", game_initiated, 1);
        for (int s = 5; s > 0; s--) begin
            repeat (9) tick();
            check("t_hold", time_left, s);
            check("t_not_over", game_over, 0);
            tick();
            check("t_step", time_left, s - 1);
        end
        check("t_go", game_over, 1);
        check("t_gi_low", game_initiated, 0);
        check("t_winner_draw", winner, 3);

        // Simultaneous goals: 1-1, 2-2, then 3-3 ends in a draw
        start_match();
        blue_score_up = ~blue_score_up;
        red_score_up  = ~red_score_up;
        repeat (2) tick();
        check("sim1_blue", blue_score, 1);
        check("sim1_red", red_score, 1);
        repeat (4) tick();
        check("sim1_resume", game_initiated, 1);
        blue_score_up = ~blue_score_up;
        red_score_up  = ~red_score_up;
        repeat (2) tick();
        check("sim2_blue", blue_score, 2);
        check("sim2_red", red_score, 2);
        check("sim2_gi", game_initiated, 0);
        repeat (4) tick();
        check("sim2_resume", game_initiated, 1);
        blue_score_up = ~blue_score_up;
        red_score_up  = ~red_score_up;
        repeat (2) tick();
        check("sim3_blue", blue_score, 3);
        check("sim3_red", red_score, 3);
        check("sim3_go", game_over, 1);
        check("sim3_winner", winner, 3);

        // Reset in the middle of a goal pause, then a fresh match
        start_match();
        red_score_up = ~red_score_up;
        repeat (2) tick();
        check("mid_red", red_score, 1);
        check("mid_pause_gi", game_initiated, 0);
        reset = 1'b1;
        tick();
        check("mid_rst_gi", game_initiated, 0);
        check("mid_rst_go", game_over, 0);
        check("mid_rst_red", red_score, 0);
        check("mid_rst_time", time_left, 5);
        check("mid_rst_winner", winner, 0);
        reset = 1'b0;
        tick();
        check("post_rst_idle", game_initiated, 0);
        start_match();
        check("fresh_gi", game_initiated, 1);
        check("fresh_time", time_left, 5);
        blue_score_up = ~blue_score_up;
        repeat (2) tick();
        check("fresh_blue", blue_score, 1);
        check("fresh_red", red_score, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
